// File: rtl/axi_lite_master_param.sv
// AXI4-Lite master with a single outstanding transaction. A command on the
// cmd_* port becomes one AXI read or write; the result comes back as a
// one-cycle rsp_valid pulse. An optional watchdog aborts a transaction that
// the slave does not finish within TIMEOUT cycles.
module axi_lite_master_param #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    // command / response side
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    // AXI write address
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    // AXI write data
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    // AXI write response
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    // AXI read address
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    // AXI read data
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    localparam int STRB_W = DATA_W / 8;
    // Counter wide enough to hold TIMEOUT-1 plus one spare bit for the
    // incremented value used in the compare.
    localparam int CNT_W  = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W:0] LIMIT = (TIMEOUT == 0) ? '0 : (CNT_W + 1)'(TIMEOUT - 1);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (DATA_W != 32 && DATA_W != 64) begin : g_illegal_data_w
        $error("axi_lite_master_param: DATA_W must be 32 or 64");
    end

    typedef enum logic [2:0] {
        IDLE,
        WREQ,
        WRESP,
        RREQ,
        RDATA
    } state_t;

    // Every output is a flop; this struct is the complete output register.
    typedef struct packed {
        logic              cmd_ready;
        logic [ADDR_W-1:0] awaddr;
        logic              awvalid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              wvalid;
        logic              bready;
        logic [ADDR_W-1:0] araddr;
        logic              arvalid;
        logic              rready;
        logic              rsp_valid;
        logic [DATA_W-1:0] rsp_rdata;
        logic [1:0]        rsp_resp;
        logic              rsp_timeout;
    } out_t;

    // Idle and ready for a command straight out of reset.
    localparam out_t RESET_OUT = '{cmd_ready: 1'b1, default: '0};

    state_t           state, state_d;
    logic [CNT_W-1:0] count, count_d;
    logic [CNT_W:0]   count_inc;
    logic             timeout_hit;
    logic             abort;
    out_t             q, d;

    // Value the counter takes at the end of this cycle; the abort fires when
    // that value reaches TIMEOUT-1, so rsp_valid lands TIMEOUT cycles after
    // acceptance.
    assign count_inc   = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_hit = (TIMEOUT != 0) && (count_inc >= LIMIT);

    // Next-state, watchdog and next-output logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state;
        count_d       = count;
        d             = q;
        d.rsp_valid   = 1'b0;
        abort         = 1'b0;

        if (state != IDLE) begin
            count_d = count_inc[CNT_W-1:0];
        end

        case (state)
            IDLE: begin
                if (cmd_valid && q.cmd_ready) begin
                    count_d = '0;
                    if (cmd_write) begin
                        state_d   = WREQ;
                        d.awaddr  = cmd_addr;
                        d.wdata   = cmd_wdata;
                        d.wstrb   = cmd_wstrb;
                        d.awvalid = 1'b1;
                        d.wvalid  = 1'b1;
                    end else begin
                        state_d   = RREQ;
                        d.araddr  = cmd_addr;
                        d.arvalid = 1'b1;
                    end
                end
            end

            WREQ: begin
                // Each channel drops its valid on its own handshake.
                d.awvalid = q.awvalid && !m_axi_awready;
                d.wvalid  = q.wvalid && !m_axi_wready;
                if (timeout_hit) begin
                    abort = 1'b1;
                end else if (!d.awvalid && !d.wvalid) begin
                    state_d  = WRESP;
                    d.bready = 1'b1;
                end
            end

            WRESP: begin
                // Completion is checked before the watchdog so it wins a tie.
                if (m_axi_bvalid) begin
                    state_d       = IDLE;
                    d.bready      = 1'b0;
                    d.rsp_valid   = 1'b1;
                    d.rsp_resp    = m_axi_bresp;
                    d.rsp_rdata   = '0;
                    d.rsp_timeout = 1'b0;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end

            RREQ: begin
                if (timeout_hit) begin
                    abort = 1'b1;
                end else if (m_axi_arready) begin
                    state_d   = RDATA;
                    d.arvalid = 1'b0;
                    d.rready  = 1'b1;
                end
            end

            RDATA: begin
                if (m_axi_rvalid) begin
                    state_d       = IDLE;
                    d.rready      = 1'b0;
                    d.rsp_valid   = 1'b1;
                    d.rsp_resp    = m_axi_rresp;
                    d.rsp_rdata   = m_axi_rdata;
                    d.rsp_timeout = 1'b0;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d       = IDLE;
            d.awvalid     = 1'b0;
            d.wvalid      = 1'b0;
            d.bready      = 1'b0;
            d.arvalid     = 1'b0;
            d.rready      = 1'b0;
            d.rsp_valid   = 1'b1;
            d.rsp_timeout = 1'b1;
            d.rsp_resp    = RESP_SLVERR;
            d.rsp_rdata   = '0;
        end

        d.cmd_ready = (state_d == IDLE);
    end

    // State and watchdog counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_OUT;
        end else begin
            q <= d;
        end
    end

    assign cmd_ready     = q.cmd_ready;
    assign m_axi_awaddr  = q.awaddr;
    assign m_axi_awvalid = q.awvalid;
    assign m_axi_wdata   = q.wdata;
    assign m_axi_wstrb   = q.wstrb;
    assign m_axi_wvalid  = q.wvalid;
    assign m_axi_bready  = q.bready;
    assign m_axi_araddr  = q.araddr;
    assign m_axi_arvalid = q.arvalid;
    assign m_axi_rready  = q.rready;
    assign rsp_valid     = q.rsp_valid;
    assign rsp_rdata     = q.rsp_rdata;
    assign rsp_resp      = q.rsp_resp;
    assign rsp_timeout   = q.rsp_timeout;

endmodule

// File: tb/tb_axi_lite_master_param.sv
// Bench for axi_lite_master_param (64-bit data, 16-cycle timeout). A slave
// that reacts to the DUT is driven per cycle; the expected response cycle and
// values come from a closed-form latency/timeout model.
module tb_axi_lite_master_param;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int STRB_W  = DATA_W / 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_wstrb;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [STRB_W-1:0] m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    int checks = 0;
    int errors = 0;
    int last_hs_a;   // cycle of AW (write) or AR (read) handshake in last txn
    int last_hs_b;   // cycle of W handshake in last write

    always #5 clk = ~clk;

    axi_lite_master_param #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .rsp_timeout  (rsp_timeout),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready)
    );

    task automatic slave_idle();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rresp   = 2'b00;
        m_axi_rdata   = '0;
    endtask

    // One transaction. Called and returns at a negedge. For writes dly_a/dly_b
    // are the AW/W ready delays; for reads dly_a is the AR delay. rsp_dly is
    // the slave's B/R latency after the request handshakes.
    task automatic run_txn(input string name, input logic wr,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                           input logic [STRB_W-1:0] wstrb, input int dly_a, input int dly_b,
                           input int rsp_dly, input logic [1:0] resp,
                           input logic [DATA_W-1:0] rdata, input int tail);
        int c_done, exp_cycle, n_rsp, wait_n;
        int aw_hs, w_hs, ar_hs, b_hs, r_hs;
        bit exp_to;
        logic [1:0] exp_resp;
        logic [DATA_W-1:0] exp_rdata;
        logic [4:0] exp_vr, got_vr;

        // reference model: cycle of the completing handshake, then watchdog
        if (wr) c_done = 1 + ((dly_a > dly_b) ? dly_a : dly_b) + 1 + rsp_dly;
        else    c_done = 1 + dly_a + 1 + rsp_dly;
        exp_to    = (c_done > TIMEOUT - 1);
        exp_cycle = exp_to ? TIMEOUT : c_done + 1;
        exp_resp  = exp_to ? 2'b10 : resp;
        exp_rdata = (exp_to || wr) ? '0 : rdata;

        wait_n = 0;
        while (cmd_ready !== 1'b1 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cmd_ready_idle: got %b want 1", name, cmd_ready);
            return;
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        @(posedge clk);   // acceptance edge = cycle 0

        aw_hs = -1; w_hs = -1; ar_hs = -1; b_hs = -1; r_hs = -1;
        n_rsp = 0;
        for (int k = 1; k <= exp_cycle + tail; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // scramble the command bus: the DUT must use its captured copy
                cmd_valid = 1'b0;
                cmd_write = ~wr;
                cmd_addr  = ~addr;
                cmd_wdata = ~wdata;
                cmd_wstrb = ~wstrb;
            end

            checks++;
            if (cmd_ready !== (k >= exp_cycle)) begin
                errors++;
                $display("FAIL %s cmd_ready cyc %0d: got %b want %b", name, k, cmd_ready, k >= exp_cycle);
            end

            if (rsp_valid === 1'b1) begin
                n_rsp++;
                checks++;
                if (k != exp_cycle || rsp_timeout !== exp_to || rsp_resp !== exp_resp || rsp_rdata !== exp_rdata) begin
                    errors++;
                    $display("FAIL %s rsp: got cyc %0d to %b resp %b rdata %h, want cyc %0d to %b resp %b rdata %h",
                             name, k, rsp_timeout, rsp_resp, rsp_rdata, exp_cycle, exp_to, exp_resp, exp_rdata);
                end
            end

            exp_vr[4] = wr && aw_hs < 0 && k < exp_cycle;
            exp_vr[3] = wr && w_hs < 0 && k < exp_cycle;
            exp_vr[2] = wr && aw_hs >= 0 && w_hs >= 0 && k > ((aw_hs > w_hs) ? aw_hs : w_hs)
                        && b_hs < 0 && k < exp_cycle;
            exp_vr[1] = !wr && ar_hs < 0 && k < exp_cycle;
            exp_vr[0] = !wr && ar_hs >= 0 && k > ar_hs && r_hs < 0 && k < exp_cycle;
            got_vr = {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready};
            checks++;
            if (got_vr !== exp_vr) begin
                errors++;
                $display("FAIL %s aw/w/b/ar/r handshake signals cyc %0d: got %b want %b", name, k, got_vr, exp_vr);
            end

            if (m_axi_awvalid === 1'b1 || m_axi_wvalid === 1'b1) begin
                checks++;
                if (m_axi_awaddr !== addr || m_axi_wdata !== wdata || m_axi_wstrb !== wstrb) begin
                    errors++;
                    $display("FAIL %s write payload cyc %0d: got %h/%h/%h want %h/%h/%h", name, k,
                             m_axi_awaddr, m_axi_wdata, m_axi_wstrb, addr, wdata, wstrb);
                end
            end
            if (m_axi_arvalid === 1'b1) begin
                checks++;
                if (m_axi_araddr !== addr) begin
                    errors++;
                    $display("FAIL %s araddr cyc %0d: got %h want %h", name, k, m_axi_araddr, addr);
                end
            end

            // slave reacts to what it has seen so far
            m_axi_awready = wr && (k == 1 + dly_a);
            m_axi_wready  = wr && (k == 1 + dly_b);
            m_axi_arready = !wr && (k == 1 + dly_a);
            m_axi_bvalid  = aw_hs >= 0 && w_hs >= 0 && b_hs < 0
                            && k >= ((aw_hs > w_hs) ? aw_hs : w_hs) + 1 + rsp_dly;
            m_axi_bresp   = resp;
            m_axi_rvalid  = ar_hs >= 0 && r_hs < 0 && k >= ar_hs + 1 + rsp_dly;
            m_axi_rresp   = resp;
            m_axi_rdata   = m_axi_rvalid ? rdata : {$urandom, $urandom};

            if (m_axi_awvalid && m_axi_awready) aw_hs = k;
            if (m_axi_wvalid && m_axi_wready)   w_hs  = k;
            if (m_axi_arvalid && m_axi_arready) ar_hs = k;
            if (m_axi_bvalid && m_axi_bready)   b_hs  = k;
            if (m_axi_rvalid && m_axi_rready)   r_hs  = k;
        end
        slave_idle();

        checks++;
        if (n_rsp != 1) begin
            errors++;
            $display("FAIL %s rsp_count: got %0d want 1", name, n_rsp);
        end
        last_hs_a = wr ? aw_hs : ar_hs;
        last_hs_b = w_hs;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
             rsp_valid, rsp_timeout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_handshake_outputs: got %b want 0000000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                      rsp_valid, rsp_timeout});
        end
        checks++;
        if (rsp_rdata !== '0 || rsp_resp !== 2'b00) begin
            errors++;
            $display("FAIL reset_rsp: got rdata %h resp %b want 0", rsp_rdata, rsp_resp);
        end
        checks++;
        if (m_axi_awaddr !== '0 || m_axi_araddr !== '0 || m_axi_wdata !== '0 || m_axi_wstrb !== '0) begin
            errors++;
            $display("FAIL reset_payload: got %h %h %h %h want 0", m_axi_awaddr, m_axi_araddr,
                     m_axi_wdata, m_axi_wstrb);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        run_txn("wr_basic", 1'b1, 32'h10, 64'h0000_0000_DEAD_BEEF, 8'h0F, 0, 0, 0, 2'b00, '0, 2);
        checks++;
        if (last_hs_a != 1 || last_hs_b != 1) begin
            errors++;
            $display("FAIL wr_basic hs_cycle: got aw %0d w %0d want 1 1", last_hs_a, last_hs_b);
        end
    endtask

    task automatic test_write_skew();
        run_txn("wr_skew", 1'b1, 32'h44, 64'hA5A5_5A5A_0F0F_F0F0, 8'hC3, 0, 3, 1, 2'b01, '0, 2);
        checks++;
        if (last_hs_a != 1 || last_hs_b != 4) begin
            errors++;
            $display("FAIL wr_skew hs_cycle: got aw %0d w %0d want 1 4", last_hs_a, last_hs_b);
        end
    endtask

    task automatic test_wide_strobe();
        run_txn("wr_wide", 1'b1, 32'h1000_0008, 64'h0123_4567_89AB_CDEF, 8'h0F, 1, 0, 2, 2'b00, '0, 2);
    endtask

    task automatic test_read();
        run_txn("rd_fast", 1'b0, 32'h24, '0, '0, 0, 0, 0, 2'b00, 64'h1111_2222_3333_4444, 2);
        run_txn("rd_slverr", 1'b0, 32'h20, '0, '0, 0, 0, 5, 2'b10, 64'h0000_0000_1234_5678, 2);
    endtask

    task automatic test_timeout();
        run_txn("to_b_never", 1'b1, 32'h30, 64'h55, 8'hFF, 0, 0, 1000, 2'b00, '0, 2);
        run_txn("to_r_never", 1'b0, 32'h34, '0, '0, 0, 0, 1000, 2'b00, 64'h99, 2);
        run_txn("to_aw_never", 1'b1, 32'h38, 64'h77, 8'h01, 100, 0, 0, 2'b00, '0, 2);
        run_txn("edge_b_ok", 1'b1, 32'h3C, 64'h66, 8'h80, 0, 0, 13, 2'b11, '0, 2);
        run_txn("edge_b_to", 1'b1, 32'h40, 64'h67, 8'h80, 0, 0, 14, 2'b11, '0, 2);
        run_txn("edge_r_ok", 1'b0, 32'h48, '0, '0, 0, 0, 13, 2'b01, 64'hFEED, 2);
        run_txn("edge_r_to", 1'b0, 32'h4C, '0, '0, 0, 0, 14, 2'b01, 64'hFEED, 2);
    endtask

    task automatic test_reset_in_rdata();
        int n_rsp;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h50;
        @(posedge clk);
        @(negedge clk);           // cycle 1: RREQ
        cmd_valid     = 1'b0;
        m_axi_arready = 1'b1;
        @(negedge clk);           // cycle 2: RDATA
        m_axi_arready = 1'b0;
        checks++;
        if (m_axi_rready !== 1'b1) begin
            errors++;
            $display("FAIL rst_rdata in_rdata: got rready %b want 1", m_axi_rready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_axi_rready, m_axi_arvalid, cmd_ready, rsp_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL rst_rdata after_rst: got rready/arvalid/cmd_ready/rsp_valid %b want 0010",
                     {m_axi_rready, m_axi_arvalid, cmd_ready, rsp_valid});
        end
        rst = 1'b0;
        m_axi_rvalid = 1'b1;      // late data must be ignored
        m_axi_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        n_rsp = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) n_rsp++;
        end
        slave_idle();
        checks++;
        if (n_rsp != 0) begin
            errors++;
            $display("FAIL rst_rdata no_rsp: got %0d pulses want 0", n_rsp);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("b2b_%0d", i), 1'(i % 2), $urandom, {$urandom, $urandom},
                    STRB_W'($urandom_range(0, 255)), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 3), 2'($urandom_range(0, 3)), {$urandom, $urandom}, 0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn($sformatf("rnd_%0d", i), 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom},
                    STRB_W'($urandom_range(0, 255)), $urandom_range(0, 6), $urandom_range(0, 6),
                    $urandom_range(0, 12), 2'($urandom_range(0, 3)), {$urandom, $urandom},
                    $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        slave_idle();

        test_reset();
        test_write_basic();
        test_write_skew();
        test_wide_strobe();
        test_read();
        test_timeout();
        test_reset_in_rdata();
        test_back_to_back();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
